// File: rtl/mash_decimator.sv
// Third-order CIC (sinc^3) decimator for the MASH modulator output stream.
// Integrates at the input rate, decimates by 2^LOG2_R, and differentiates at the output rate.
module mash_decimator #(
  parameter  int IN_W   = 4,
  parameter  int LOG2_R = 6,
  localparam int ACC_W  = IN_W + 3 * LOG2_R
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_sample,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] out_data
);

  localparam logic [LOG2_R-1:0] CNT_LAST = '1;

  logic signed [ACC_W-1:0] x;
  logic signed [ACC_W-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic signed [ACC_W-1:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
  logic signed [ACC_W-1:0] c1, c2, c3;
  logic signed [ACC_W-1:0] out_data_q, out_data_d;
  logic [LOG2_R-1:0]       cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;

  assign x = {{(ACC_W - IN_W){in_sample[IN_W-1]}}, in_sample};

  // Comb section sees the pre-edge i3 and delays; wrap-around is intentional and exact.
  assign c1 = i3_q - d0_q;
  assign c2 = c1 - d1_q;
  assign c3 = c2 - d2_q;

  always_comb begin
    // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latch).
    i1_d        = i1_q;
    i2_d        = i2_q;
    i3_d        = i3_q;
    d0_d        = d0_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      i1_d  = i1_q + x;
      i2_d  = i2_q + i1_q;
      i3_d  = i3_q + i2_q;
      cnt_d = cnt_q + LOG2_R'(1);
      if (cnt_q == CNT_LAST) begin
        d0_d        = i3_q;
        d1_d        = c1;
        d2_d        = c2;
        out_data_d  = c3;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_q        <= '0;
      i2_q        <= '0;
      i3_q        <= '0;
      d0_q        <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values of its neighbours.
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      i3_q        <= i3_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_mash_decimator.sv
// Directed bench for mash_decimator at default parameters (R = 64, ACC_W = 22).
// Expected values are hand-derived: for constant +1, c0 at event m is C(64m-1, 3).
module tb_mash_decimator;

  localparam int ACC_W = 22;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic signed [3:0]       in_sample = '0;
  logic                    out_valid;
  logic signed [ACC_W-1:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  longint outs[$];
  int     out_cyc[$];

  // Constant +1 from reset: three transients then x * R^3.
  longint exp_one[6] = '{39711, 214242, 262143, 262144, 262144, 262144};

  mash_decimator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sample(in_sample),
    .out_valid(out_valid),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 ns later and log any output.
  task automatic step(input logic v, input int s);
    in_valid  = v;
    in_sample = s[3:0];
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid) begin
      outs.push_back(longint'(out_data));
      out_cyc.push_back(cyc);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    outs.delete();
    out_cyc.delete();
    cyc = 0;
  endtask

  task automatic check_one_seq(input string tag, input int first, input int spacing);
    check($sformatf("%s_count", tag), outs.size(), 6);
    for (int i = 0; i < 6 && i < outs.size(); i++) begin
      check($sformatf("%s_val%0d", tag, i), outs[i], exp_one[i]);
      check($sformatf("%s_cyc%0d", tag, i), out_cyc[i], first + i * spacing);
    end
  endtask

  initial begin
    // Reset holds everything at zero even with a valid nonzero input present.
    in_valid  = 1'b1;
    in_sample = 4'sd7;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 7);
      check($sformatf("rst_valid%0d", k), out_valid, 0);
      check($sformatf("rst_data%0d", k), out_data, 0);
    end
    check("rst_no_outputs", outs.size(), 0);
    rst_n = 1'b1;
    outs.delete();
    out_cyc.delete();
    cyc = 0;

    // Constant +1, continuous.
    for (int k = 0; k < 6 * 64; k++) step(1'b1, 1);
    check_one_seq("const1", 64, 64);

    // Mid-run reset after 100 accepted samples clears outputs asynchronously.
    do_reset();
    for (int k = 0; k < 100; k++) step(1'b1, 1);
    check("mid_pre_data", out_data, 39711);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", out_data, 0);
    check("mid_rst_valid", out_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    outs.delete();
    out_cyc.delete();
    cyc = 0;
    for (int k = 0; k < 6 * 64; k++) step(1'b1, 1);
    check_one_seq("mid_restart", 64, 64);

    // Alternating 0,1,...: steady value is 0.5 * R^3.
    do_reset();
    for (int k = 0; k < 8 * 64; k++) step(1'b1, k & 1);
    check("alt_count", outs.size(), 8);
    for (int i = 3; i < 8 && i < outs.size(); i++)
      check($sformatf("alt_val%0d", i), outs[i], 131072);

    // Extremes: -8 then +7, 200 outputs each; integrators wrap repeatedly.
    do_reset();
    for (int k = 0; k < 12800; k++) step(1'b1, -8);
    for (int k = 0; k < 12800; k++) step(1'b1, 7);
    check("ext_count", outs.size(), 400);
    for (int i = 3; i < 200 && i < outs.size(); i++)
      check($sformatf("ext_neg%0d", i), outs[i], -2097152);
    for (int i = 203; i < 400 && i < outs.size(); i++)
      check($sformatf("ext_pos%0d", i), outs[i], 1835008);

    // Valid every other cycle: same values, 128-cycle spacing; idle samples carry junk.
    do_reset();
    for (int k = 1; k <= 6 * 128; k++) step(k[0], k[0] ? 1 : -8);
    check_one_seq("gapped", 127, 128);

    // Five idle cycles where the 64th sample would land delay the event by five.
    do_reset();
    for (int k = 1; k <= 389; k++) begin
      if (k >= 64 && k <= 68) step(1'b0, 7);
      else                    step(1'b1, 1);
    end
    check_one_seq("gap64", 69, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
